// File: rtl/memory_interface_ctrl.sv
// Memory interface controller: single/burst read/write to an asynchronous-handshake memory,
// with per-beat programmable wait states and an rdy-low timeout abort.
module memory_interface_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int BL_W        = 2,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BL_W-1:0]   burst_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              oe,
    output logic              we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              beat_done,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        present_state
);

    // Wait counter is sized so WAIT_CYCLES=0 still yields a non-zero-width vector.
    localparam int WC_W = $clog2(WAIT_CYCLES + 2);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_RELOAD = WC_W'(WAIT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHKRW = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BL_W-1:0]   blen_q, blen_d;
    logic [BL_W-1:0]   beat_q, beat_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              beat_done_s;

    // State, request latches, counters and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            blen_q   <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            to_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            blen_q   <= blen_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            to_q     <= to_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic; rdy is only honoured once the wait counter has drained.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        to_d        = to_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        beat_done_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    blen_d  = burst_len;
                    beat_d  = '0;
                    state_d = S_CHKRW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHKRW: begin
                state_d = rw_q ? S_READ : S_WRITE;
                wait_d  = WAIT_RELOAD;
                to_d    = '0;
            end
            S_READ, S_WRITE: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WC_W'(1'b1);
                end else if (rdy) begin
                    beat_done_s = 1'b1;
                    if (state_q == S_READ) begin
                        rdata_d  = mem_rdata;
                        rvalid_d = 1'b1;
                    end else begin
                        rdata_d  = rdata_q;
                    end
                    if (beat_q == blen_q) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BL_W'(1'b1);
                        wait_d = WAIT_RELOAD;
                        to_d   = '0;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1'b1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign oe            = (state_q == S_READ);
    assign we            = (state_q == S_WRITE);
    assign mem_addr      = (state_q == S_IDLE) ? '0 : addr_q + ADDR_W'(beat_q);
    assign mem_wdata     = (state_q == S_WRITE) ? wdata : '0;
    assign beat_done     = beat_done_s;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERROR);
    assign present_state = state_q;

endmodule

// File: doc/memory_interface_ctrl.md
# memory_interface_ctrl

Parametrised memory interface controller: accepts a single or burst read/write request from a host, drives `oe`/`we`, address and write data to an asynchronous-handshake memory, inserts a programmable number of wait states before sampling memory `rdy`, and aborts with an error pulse if `rdy` stays low too long. It sits between the host bus logic and the external memory model. It replaces the fixed 4-state IDLE/CHKRW/READ/WRITE controller with burst, wait-state and timeout support.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `BL_W`, 2: burst-length field width; beats per request = `burst_len`+1, so 1..2^BL_W.
- `WAIT_CYCLES`, 2: wait states per beat before `rdy` is honoured; 0 is legal.
- `TIMEOUT`, 16: consecutive rdy-low cycles after the wait states that cause an abort; must be ≥1.

Ports:
- `clk`  in  1  single clock; all flops on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  host request; sampled only in IDLE.
- `rw`  in  1  1 = read, 0 = write; latched with `req`.
- `addr`  in  ADDR_W  start address; latched with `req`.
- `burst_len`  in  BL_W  beats−1; latched with `req`.
- `wdata`  in  DATA_W  write data for the current beat; host advances it on `beat_done`.
- `rdy`  in  1  memory ready.
- `mem_rdata`  in  DATA_W  memory read data.
- `oe`  out  1  output enable, high throughout READ.
- `we`  out  1  write enable, high throughout WRITE.
- `mem_addr`  out  ADDR_W  latched address + beat index.
- `mem_wdata`  out  DATA_W  equals `wdata` while in WRITE, else 0.
- `beat_done`  out  1  combinational; high in the cycle a beat completes.
- `rdata`  out  DATA_W  registered read data.
- `rvalid`  out  1  one-cycle pulse, `rdata` valid.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse, request completed.
- `err`  out  1  one-cycle pulse, request aborted on timeout.
- `present_state`  out  3  state encoding, for checking.

## Operation
- States/encoding: IDLE=0, CHKRW=1, READ=2, WRITE=3, DONE=4, ERROR=5; codes 6-7 → IDLE next edge.
- IDLE: `oe`=`we`=0. On `req`=1, latch `rw`, `addr`, `burst_len`; clear beat index; → CHKRW.
- CHKRW: one cycle; → READ if latched `rw`=1, else WRITE; load wait counter with `WAIT_CYCLES`, clear timeout counter.
- READ/WRITE: wait counter decrements to 0; `rdy` ignored while nonzero. With counter 0: `rdy`=1 → `beat_done`=1 (READ also captures `mem_rdata` into `rdata`, `rvalid`=1 next cycle). Then last beat → DONE; otherwise beat index+1, wait counter reloaded, timeout cleared, stay.
- With wait counter 0 and `rdy`=0: timeout counter increments; the `TIMEOUT`-th such cycle → ERROR (no beat completes).
- DONE: `done`=1, `oe`=`we`=0, → IDLE. ERROR: `err`=1, `oe`=`we`=0, → IDLE; partial `rvalid` pulses already issued stand.
- `mem_addr` = latched addr + beat index, wraps modulo 2^ADDR_W; 0 in IDLE.
- `req` while busy is ignored, not queued. `rw`/`addr` changes after latch have no effect.
- Reset (`reset_n`=0, any time incl. mid-burst): state IDLE, all counters and outputs 0 immediately.

## Timing
- `req` sampled at edge N: CHKRW after N, READ/WRITE after N+1.
- Single beat, `rdy` held high: `beat_done` in cycle after edge N+1+W (W=`WAIT_CYCLES`), `done` after N+2+W.
- B beats, `rdy` held high: `done` after edge N+1+B·(W+1).
- `rvalid` one cycle after each read `beat_done`; last one coincides with `done`.
- Earliest new `req` sample: the IDLE cycle after DONE/ERROR.

## Test plan
- Reset: `reset_n`=0 mid-READ → `oe`=0, `present_state`=0, `busy`=0, `rdata`=0 without a clock edge.
- Single read, W=2, addr=0x10, `mem_rdata`=0xA5, `rdy`=1 → `oe` high 3 cycles, `mem_addr`=0x10, `rdata`=0xA5 with `rvalid` and `done` 4 cycles after req edge.
- 4-beat write, addr=0xFE, `wdata` 0x11,0x22,0x33,0x44 advanced on `beat_done` → `mem_addr` 0xFE,0xFF,0x00,0x01, `we` high 12 cycles, one `done`.
- Wait-state gating: W=2, `rdy`=1 only in first READ cycle then 0 → no `beat_done`; `rdy`=1 again after counter 0 → beat completes.
- Timeout: TIMEOUT=16, `rdy` stuck 0 → `err` pulse after 16 rdy-low cycles past the wait states, no `done`, back to IDLE.
- `req` pulsed during busy → ignored; W=0 read with `rdy`=1 → `done` 2 cycles after req edge.
